ram_sdp: RTL
============

RAM_SDP -- requirements
Module: ram_sdp

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits; multiple of 8.
REQ-002 Parameter ADDR_W, default 4, address width; depth DEPTH = 2**ADDR_W words.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 Parameter RDW_MODE, default 0, same-address read-during-write: 0 = old data, 1 = new data.
REQ-005 Derived BE_W = DATA_W/8, byte-enable width.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 we  in  1  write request.
REQ-009 waddr  in  ADDR_W  write address.
REQ-010 wdata  in  DATA_W  write data.
REQ-011 wbe  in  BE_W  byte enables; bit i covers wdata[8i+7:8i].
REQ-012 re  in  1  read request.
REQ-013 raddr  in  ADDR_W  read address.
REQ-014 rdata  out  DATA_W  read data, registered.
REQ-015 rvalid  out  1  one-cycle pulse; rdata carries the requested word.
REQ-016 init_done  out  1  high once the memory clear has completed.

Function
REQ-017 Block SHALL have two states: CLEAR and READY.
REQ-018 CLEAR: each cycle SHALL write all-zero to clr_addr and increment it, starting at 0.
REQ-019 CLEAR SHALL move to READY on the cycle after the write to DEPTH-1; the clear lasts exactly DEPTH cycles after rst deasserts.
REQ-020 init_done SHALL be 0 in CLEAR and 1 in READY.
REQ-021 In CLEAR, we and re SHALL be ignored: no user write, and rvalid stays 0.
REQ-022 READY, we=1: each byte lane i with wbe[i]=1 SHALL update at waddr on the edge; lanes with wbe[i]=0 keep their value.
REQ-023 we=1 with wbe all-zero SHALL leave memory unchanged.
REQ-024 READY, re=1 on edge N: rdata SHALL present mem[raddr] and rvalid SHALL be 1 in the cycle after edge N+RD_LAT-1.
REQ-025 RD_LAT=2 SHALL add one output register stage after the array read; rvalid SHALL be pipelined to match.
REQ-026 Back-to-back reads (re=1 every cycle) SHALL give one result per cycle, in request order.
REQ-027 When no read completes, rvalid SHALL be 0 and rdata SHALL hold its last value.
REQ-028 re=1, we=1 and raddr==waddr on the same edge, RDW_MODE=0: SHALL return the pre-write word.
REQ-029 Same case, RDW_MODE=1: SHALL return the post-write word, merged per wbe.
REQ-030 Reads and writes to different addresses on the same edge SHALL be independent.
REQ-031 Illegal DATA_W (not a multiple of 8) or RD_LAT not in {1,2} SHALL stop elaboration with an error.

Reset
REQ-032 rst=1 SHALL, without waiting for clk, set state=CLEAR, clr_addr=0, rdata=0, rvalid=0, init_done=0, and clear the read pipeline.
REQ-033 While rst=1, memory contents SHALL NOT change.
REQ-034 Reset during READY or mid-CLEAR SHALL drop in-flight reads (no rvalid) and restart the full clear from address 0 after release.

Verification
REQ-035 Defaults: release rst, count cycles to init_done=1 -> exactly 16; then read addr 0..15 -> all 8'h00, each with one rvalid pulse.
REQ-036 Defaults: write addr 1=8'hA5 and addr 2=8'h5A (wbe=1); read 1 then 2 -> 8'hA5 then 8'h5A, rvalid one cycle after each re edge.
REQ-037 DATA_W=16: write addr 3=16'h1234 (wbe=2'b11), then 16'hABCD with wbe=2'b10 -> read 16'hAB34.
REQ-038 Addr 5 holds 8'h11; write 8'h22 and read addr 5 on the same edge -> RDW_MODE=0 gives 8'h11, RDW_MODE=1 gives 8'h22; next read gives 8'h22 in both.
REQ-039 RD_LAT=2: re held 3 cycles on addr 1,2,3 (8'hA1,8'hA2,8'hA3) -> rvalid high for 3 cycles, starting 2 cycles after the first re edge; data in order.
REQ-040 Write 8'hFF to addr 7; issue re and assert rst before rvalid -> no rvalid, init_done=0, rdata=0; after release and 16 clear cycles, addr 7 reads 8'h00.

Source files
------------

// File: rtl/ram_sdp.sv
// Simple dual-port RAM with byte enables, self-clearing after reset,
// configurable read latency and read-during-write behaviour.
module ram_sdp #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 4,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0,
  localparam int BE_W    = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   wbe,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  if (DATA_W <= 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
    $error("ram_sdp: DATA_W must be a positive multiple of 8");
  end
  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("ram_sdp: RD_LAT must be 1 or 2");
  end

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              rd_fire, wr_fire;
  logic [DATA_W-1:0] rd_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= CLEAR;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      CLEAR:   if (clr_addr == '1) state_nx = READY;
      READY:   state_nx = READY;
      default: state_nx = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
  end

  assign init_done = (state == READY);
  assign rd_fire   = (state == READY) && re;
  assign wr_fire   = (state == READY) && we;

  // The array has no reset; rst only blocks writes so contents survive it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_addr] <= '0;
      end else if (wr_fire) begin
        for (int i = 0; i < BE_W; i++)
          if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_word = mem[raddr];
    if (RDW_MODE != 0 && wr_fire && waddr == raddr) begin
      for (int i = 0; i < BE_W; i++)
        if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata  <= '0;
        rvalid <= 1'b0;
      end else begin
        rvalid <= rd_fire;
        if (rd_fire) rdata <= rd_word;
      end
    end
  end else begin : g_lat2
    logic [DATA_W-1:0] s1_data;
    logic              s1_valid;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_data  <= '0;
        s1_valid <= 1'b0;
        rdata    <= '0;
        rvalid   <= 1'b0;
      end else begin
        s1_valid <= rd_fire;
        if (rd_fire) s1_data <= rd_word;
        rvalid <= s1_valid;
        if (s1_valid) rdata <= s1_data;
      end
    end
  end

endmodule
